// File: rtl/acq_pkg.sv
// Shared types and constants for the acquisition sequencer.
package acq_pkg;

  localparam int unsigned TMO_W   = 24;
  localparam int unsigned HOLD_W  = 16;
  localparam int unsigned DECIM_W = 12;
  localparam int unsigned FCNT_W  = 16;
  localparam int unsigned MODE_W  = 2;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_CAPTURE = 3'd2,
    ST_DONE    = 3'd3,
    ST_HOLDOFF = 3'd4
  } acq_state_t;

  localparam logic [MODE_W-1:0] MODE_NORMAL = 2'd0;
  localparam logic [MODE_W-1:0] MODE_AUTO   = 2'd1;

  localparam logic [TMO_W-1:0]  DEF_AUTO_TIMEOUT = 24'd1_000_000;
  localparam logic [HOLD_W-1:0] DEF_HOLDOFF      = 16'd1024;

endpackage

// File: rtl/acq_control_if.sv
// Control, trigger-engine and display handshakes of the acquisition sequencer.
interface acq_control_if;
  import acq_pkg::*;

  logic                run;
  logic                single;
  logic [MODE_W-1:0]   mode;
  logic [DECIM_W-1:0]  decim;
  logic                trig_hit;
  logic                cap_done;
  logic                disp_busy;
  // force is a reserved word, hence force_cap
  logic                arm;
  logic                force_cap;
  logic                sample_en;
  logic                frame_valid;
  logic [FCNT_W-1:0]   frame_cnt;
  logic [2:0]          state_o;

  modport master (
    output run, single, mode, decim, trig_hit, cap_done, disp_busy,
    input  arm, force_cap, sample_en, frame_valid, frame_cnt, state_o
  );

  modport slave (
    input  run, single, mode, decim, trig_hit, cap_done, disp_busy,
    output arm, force_cap, sample_en, frame_valid, frame_cnt, state_o
  );

endinterface

// File: rtl/sample_tick_gen.sv
// Free-running decimation counter; sample_en fires once every decim+1 cycles.
module sample_tick_gen
  import acq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [DECIM_W-1:0] decim,
  output logic               sample_en
);

  logic [DECIM_W-1:0] cnt;

  // Down-counter reloads from decim only on wrap, so a new value lands at the next wrap.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      sample_en <= 1'b0;
    end else if (cnt == '0) begin
      cnt       <= decim;
      sample_en <= 1'b1;
    end else begin
      cnt       <= cnt - DECIM_W'(1);
      sample_en <= 1'b0;
    end
  end

endmodule

// File: rtl/acq_control.sv
// Acquisition sequencer: arms the trigger engine, forces AUTO captures and
// holds off re-arm until the display has released the captured frame.
module acq_control
  import acq_pkg::*;
#(
  parameter logic [TMO_W-1:0]  AUTO_TIMEOUT = DEF_AUTO_TIMEOUT,
  parameter logic [HOLD_W-1:0] HOLDOFF      = DEF_HOLDOFF
) (
  input  logic          clk,
  input  logic          rst,
  acq_control_if.slave  bus
);

  acq_state_t         state, state_nxt;
  logic [TMO_W-1:0]   tmo_cnt, tmo_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic               single_pend, single_pend_d;
  logic               arm_q, arm_d;
  logic               force_q, force_d;
  logic               frame_valid_q, frame_valid_d;
  logic [FCNT_W-1:0]  frame_cnt_q, frame_cnt_d;

  logic want_arm;
  logic tmo_hit;
  logic hold_done;

  assign want_arm  = bus.run | single_pend;
  // Widened compares keep AUTO_TIMEOUT = 0 / HOLDOFF = 0 free of underflow.
  assign tmo_hit   = (bus.mode == MODE_AUTO) &&
                     (({1'b0, tmo_cnt} + (TMO_W+1)'(1)) == {1'b0, AUTO_TIMEOUT});
  assign hold_done = ({1'b0, hold_cnt} + (HOLD_W+1)'(1)) >= {1'b0, HOLDOFF};

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (want_arm) state_nxt = ST_ARMED;
      ST_ARMED: begin
        if (bus.trig_hit || tmo_hit) state_nxt = ST_CAPTURE;
        else if (!want_arm)          state_nxt = ST_IDLE;
      end
      ST_CAPTURE: if (bus.cap_done) state_nxt = ST_DONE;
      ST_DONE:    state_nxt = single_pend ? ST_IDLE : ST_HOLDOFF;
      ST_HOLDOFF: if (hold_done && !bus.disp_busy) state_nxt = want_arm ? ST_ARMED : ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    arm_d         = (state_nxt == ST_ARMED) || (state_nxt == ST_CAPTURE);
    force_d       = 1'b0;
    frame_valid_d = frame_valid_q;
    frame_cnt_d   = frame_cnt_q;
    single_pend_d = single_pend | bus.single;
    tmo_d         = '0;
    hold_d        = '0;
    case (state)
      ST_ARMED: begin
        if (state_nxt == ST_ARMED) tmo_d = tmo_cnt + TMO_W'(1);
        // Buffer is about to be overwritten; a coincident trig_hit suppresses force.
        if (state_nxt == ST_CAPTURE) begin
          frame_valid_d = 1'b0;
          force_d       = !bus.trig_hit;
        end
      end
      ST_CAPTURE: begin
        if (bus.cap_done) begin
          frame_valid_d = 1'b1;
          frame_cnt_d   = frame_cnt_q + FCNT_W'(1);
        end
      end
      ST_DONE: begin
        if (state_nxt == ST_IDLE && !bus.single) single_pend_d = 1'b0;
      end
      ST_HOLDOFF: begin
        if (state_nxt == ST_HOLDOFF) hold_d = hold_done ? hold_cnt : hold_cnt + HOLD_W'(1);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt       <= '0;
      hold_cnt      <= '0;
      single_pend   <= 1'b0;
      arm_q         <= 1'b0;
      force_q       <= 1'b0;
      frame_valid_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      tmo_cnt       <= tmo_d;
      hold_cnt      <= hold_d;
      single_pend   <= single_pend_d;
      arm_q         <= arm_d;
      force_q       <= force_d;
      frame_valid_q <= frame_valid_d;
      frame_cnt_q   <= frame_cnt_d;
    end
  end

  assign bus.arm         = arm_q;
  assign bus.force_cap   = force_q;
  assign bus.frame_valid = frame_valid_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.state_o     = state;

  sample_tick_gen u_tick (
    .clk       (clk),
    .rst       (rst),
    .decim     (bus.decim),
    .sample_en (bus.sample_en)
  );

endmodule
